// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: Wishbone B3 round-robin arbiter sharing one slave among
// NUM_M masters. A granted master owns the slave for its whole CYC.
// A watchdog forces ERR when the slave stalls a strobe for TIMEOUT cycles.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   m_*             - master-side bundles, bit/slice i belongs to master i
//   m_dat_s2m       - slave read data broadcast to every master
//   m_ack/err/rty   - terminations routed to the current owner only
//   s_*             - slave-side bundle, combinational mux of the owner
//   gnt             - one-hot current owner, zero when idle
module wb_rr_arbiter #(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned DAT_W   = 32,
  parameter int unsigned ADR_W   = 32,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_M-1:0]       m_cyc,
  input  logic [NUM_M-1:0]       m_stb,
  input  logic [NUM_M-1:0]       m_we,
  input  logic [NUM_M*ADR_W-1:0] m_adr,
  input  logic [NUM_M*SEL_W-1:0] m_sel,
  input  logic [NUM_M*DAT_W-1:0] m_dat_m2s,
  input  logic [NUM_M*3-1:0]     m_cti,
  input  logic [NUM_M*2-1:0]     m_bte,
  output logic [DAT_W-1:0]       m_dat_s2m,
  output logic [NUM_M-1:0]       m_ack,
  output logic [NUM_M-1:0]       m_err,
  output logic [NUM_M-1:0]       m_rty,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [ADR_W-1:0]       s_adr,
  output logic [SEL_W-1:0]       s_sel,
  output logic [DAT_W-1:0]       s_dat_m2s,
  output logic [2:0]             s_cti,
  output logic [1:0]             s_bte,
  input  logic [DAT_W-1:0]       s_dat_s2m,
  input  logic                   s_ack,
  input  logic                   s_err,
  input  logic                   s_rty,
  output logic [NUM_M-1:0]       gnt
);

  localparam int unsigned OWN_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          WD_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             fire_q,  fire_d;

  // Per-master views of the packed request buses
  logic [ADR_W-1:0] adr_a [NUM_M];
  logic [SEL_W-1:0] sel_a [NUM_M];
  logic [DAT_W-1:0] dat_a [NUM_M];
  logic [2:0]       cti_a [NUM_M];
  logic [1:0]       bte_a [NUM_M];

  for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
    assign adr_a[i] = m_adr[i*ADR_W +: ADR_W];
    assign sel_a[i] = m_sel[i*SEL_W +: SEL_W];
    assign dat_a[i] = m_dat_m2s[i*DAT_W +: DAT_W];
    assign cti_a[i] = m_cti[i*3 +: 3];
    assign bte_a[i] = m_bte[i*2 +: 2];
  end

  // First requester after base, wrapping; base itself is searched last
  function automatic logic [OWN_W-1:0] pick(input logic [NUM_M-1:0] req,
                                            input logic [OWN_W-1:0] base);
    logic [OWN_W-1:0] res;
    logic             found;
    int unsigned      idx;
    res   = base;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_M; i++) begin
      idx = (32'(base) + i) % NUM_M;
      if (!found && req[OWN_W'(idx)]) begin
        res   = OWN_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign m_dat_s2m = s_dat_s2m;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= OWN_W'(NUM_M - 1);
      cnt_q   <= '0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
    end
  end

  // Next-state, bus mux, termination routing and watchdog
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = '0;
    fire_d    = 1'b0;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_sel     = '0;
    s_dat_m2s = '0;
    s_cti     = '0;
    s_bte     = '0;
    m_ack     = '0;
    m_err     = '0;
    m_rty     = '0;

    case (state_q)
      IDLE: begin
        if (|m_cyc) begin
          owner_d = pick(m_cyc, ptr_q);
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (m_cyc[owner_q]) begin
          s_cyc     = 1'b1;
          s_stb     = m_stb[owner_q] & ~fire_q;
          s_we      = m_we[owner_q];
          s_adr     = adr_a[owner_q];
          s_sel     = sel_a[owner_q];
          s_dat_m2s = dat_a[owner_q];
          s_cti     = cti_a[owner_q];
          s_bte     = bte_a[owner_q];
          // A forced ERR cycle swallows whatever the slave answers
          if (fire_q) begin
            m_err[owner_q] = 1'b1;
          end else begin
            m_ack[owner_q] = s_ack;
            m_err[owner_q] = s_err;
            m_rty[owner_q] = s_rty;
          end
          if (WD_EN && s_stb && !(s_ack | s_err | s_rty)) begin
            if (cnt_q == CNT_LAST) fire_d = 1'b1;
            else                   cnt_d  = cnt_q + 1'b1;
          end
        end else begin
          // Release: owner becomes the rr pointer and is searched last
          ptr_d = owner_q;
          if (|m_cyc) owner_d = pick(m_cyc, owner_q);
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An abandoned cycle never terminates
    if (rst) begin
      m_ack = '0;
      m_err = '0;
      m_rty = '0;
    end
  end

  // One-hot grant decode
  always_comb begin
    gnt = '0;
    if (state_q == OWNED) gnt[owner_q] = 1'b1;
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenarios followed by randomized traffic, each
// cycle compared against a cycle-level reference model of the arbiter.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic clk, rst;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*SW-1:0] m_sel;
  logic [NM*DW-1:0] m_dat_m2s;
  logic [NM*3-1:0]  m_cti;
  logic [NM*2-1:0]  m_bte;
  logic [DW-1:0]    m_dat_s2m;
  logic [NM-1:0]    m_ack, m_err, m_rty, gnt;
  logic             s_cyc, s_stb, s_we;
  logic [AW-1:0]    s_adr;
  logic [SW-1:0]    s_sel;
  logic [DW-1:0]    s_dat_m2s, s_dat_s2m;
  logic [2:0]       s_cti;
  logic [1:0]       s_bte;
  logic             s_ack, s_err, s_rty;

  wb_rr_arbiter #(.NUM_M(NM), .DAT_W(DW), .ADR_W(AW), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_m2s(m_dat_m2s), .m_cti(m_cti), .m_bte(m_bte), .m_dat_s2m(m_dat_s2m),
    .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_m2s(s_dat_m2s), .s_cti(s_cti), .s_bte(s_bte), .s_dat_s2m(s_dat_s2m),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner index (-1 = nobody), last owner, stall run, forced-ERR flag
  int mo    = -1;
  int mp    = NM - 1;
  int stall = 0;
  bit fire  = 1'b0;

  // Expected terminations of the last cycle and DUT snapshots taken at negedge
  logic [NM-1:0] last_ea;
  logic [NM-1:0] sg, sa, se;
  logic          sc, ss;
  logic [AW-1:0] sadr;
  logic [2:0]    scti;

  // Fairness bookkeeping on the observed grant
  int            wait_cnt [NM];
  logic [NM-1:0] prev_gnt = '0;
  logic [NM-1:0] prev_cyc = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_from(input int base, input logic [NM-1:0] req);
    for (int k = 1; k <= NM; k++)
      if (req[(base + k) % NM]) return (base + k) % NM;
    return -1;
  endfunction

  task automatic set_m(input int i, input bit c, input bit s, input bit w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [2:0] cti, input logic [1:0] bte, input logic [SW-1:0] sel);
    m_cyc[i] = c;
    m_stb[i] = s;
    m_we[i]  = w;
    m_adr[i*AW +: AW]     = a;
    m_dat_m2s[i*DW +: DW] = d;
    m_cti[i*3 +: 3]       = cti;
    m_bte[i*2 +: 2]       = bte;
    m_sel[i*SW +: SW]     = sel;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_sel = '0;
    m_dat_m2s = '0; m_cti = '0; m_bte = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_s2m = '0;
  endtask

  // One clock: compare at negedge, advance the model, return just after posedge
  task automatic cycle();
    logic [NM-1:0] eg, ea, ee, er;
    logic          act, est, ewe;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat;
    logic [SW-1:0] esel;
    logic [2:0]    ecti;
    logic [1:0]    ebte;
    int            k;
    @(negedge clk);
    eg = '0; ea = '0; ee = '0; er = '0;
    act = 1'b0; est = 1'b0; ewe = 1'b0;
    eadr = '0; edat = '0; esel = '0; ecti = '0; ebte = '0;
    if (mo >= 0) begin
      eg[mo] = 1'b1;
      act = m_cyc[mo];
    end
    if (act) begin
      est  = m_stb[mo] && !fire;
      ewe  = m_we[mo];
      eadr = m_adr[mo*AW +: AW];
      edat = m_dat_m2s[mo*DW +: DW];
      esel = m_sel[mo*SW +: SW];
      ecti = m_cti[mo*3 +: 3];
      ebte = m_bte[mo*2 +: 2];
      if (!rst) begin
        if (fire) ee[mo] = 1'b1;
        else begin
          ea[mo] = s_ack; ee[mo] = s_err; er[mo] = s_rty;
        end
      end
    end
    sg = gnt; sa = m_ack; se = m_err; sc = s_cyc; ss = s_stb; sadr = s_adr; scti = s_cti;
    check("gnt",       64'(gnt),       64'(eg));
    check("s_cyc",     64'(s_cyc),     64'(act));
    check("s_stb",     64'(s_stb),     64'(est));
    check("s_we",      64'(s_we),      64'(ewe));
    check("s_adr",     64'(s_adr),     64'(eadr));
    check("s_dat_m2s", 64'(s_dat_m2s), 64'(edat));
    check("s_sel",     64'(s_sel),     64'(esel));
    check("s_cti",     64'(s_cti),     64'(ecti));
    check("s_bte",     64'(s_bte),     64'(ebte));
    check("m_ack",     64'(m_ack),     64'(ea));
    check("m_err",     64'(m_err),     64'(ee));
    check("m_rty",     64'(m_rty),     64'(er));
    check("m_dat_s2m", 64'(m_dat_s2m), 64'(s_dat_s2m));
    last_ea = ea;

    // Fairness: a requester sees at most NM-1 other ownerships before its own
    if (gnt != '0 && gnt != prev_gnt) begin
      k = $clog2(gnt);
      check("fairness", 64'(wait_cnt[k] <= NM - 1), 64'd1);
      wait_cnt[k] = 0;
      for (int i = 0; i < NM; i++)
        if (i != k && prev_cyc[i] && m_cyc[i]) wait_cnt[i]++;
    end
    for (int i = 0; i < NM; i++)
      if (!m_cyc[i] || rst) wait_cnt[i] = 0;
    prev_gnt = gnt;
    prev_cyc = m_cyc;

    // Model advance
    if (rst) begin
      mo = -1; mp = NM - 1; stall = 0; fire = 1'b0;
    end else if (mo < 0) begin
      if (m_cyc != '0) mo = pick_from(mp, m_cyc);
      stall = 0; fire = 1'b0;
    end else if (!m_cyc[mo]) begin
      mp = mo;
      mo = pick_from(mp, m_cyc);
      stall = 0; fire = 1'b0;
    end else begin
      if (est && !(s_ack || s_err || s_rty)) stall++;
      else stall = 0;
      fire = (stall == TO);
      if (fire) stall = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int q [$];
  int exp_order [5] = '{1, 2, 4, 8, 1};
  int acks2, acks_other, beats;
  int dead;
  bit c, s;

  initial begin
    for (int i = 0; i < NM; i++) wait_cnt[i] = 0;
    last_ea = '0;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, no requests
    do_reset();
    repeat (4) cycle();
    check("idle_gnt",  64'(sg), 64'd0);
    check("idle_scyc", 64'(sc), 64'd0);
    check("idle_ack",  64'(sa), 64'd0);

    // Master 2 single write, ACK one cycle after STB
    set_m(2, 1, 1, 1, 32'h10, 32'hDEADBEEF, 3'b000, 2'b00, 4'hF);
    cycle();
    check("m2_latency_scyc0", 64'(sc), 64'd0);
    cycle();
    check("m2_scyc1", 64'(sc),   64'd1);
    check("m2_gnt",   64'(sg),   64'h4);
    check("m2_adr",   64'(sadr), 64'h10);
    acks2 = 0; acks_other = 0;
    s_ack = 1'b1;
    cycle();
    acks2 += int'(sa[2]); acks_other += int'(sa[0]) + int'(sa[1]) + int'(sa[3]);
    s_ack = 1'b0;
    set_m(2, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00, 4'h0);
    for (int t = 0; t < 3; t++) begin
      cycle();
      acks2 += int'(sa[2]); acks_other += int'(sa[0]) + int'(sa[1]) + int'(sa[3]);
    end
    check("m2_ack_once",   64'(acks2),      64'd1);
    check("m2_other_acks", 64'(acks_other), 64'd0);

    // All four masters, one ACKed access per CYC
    do_reset();
    s_ack = 1'b1;
    q.delete();
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < NM; i++) begin
        c = !last_ea[i];
        set_m(i, c, c, 0, 32'(i * 16), 32'(i), 3'b000, 2'b00, 4'hF);
      end
      cycle();
      if (sc && (q.size() == 0 || q[$] != int'(sg))) q.push_back(int'(sg));
    end
    for (int k = 0; k < 5; k++) check("rr_order", 64'(q.size() > k ? q[k] : -1), 64'(exp_order[k]));

    // Master 1 four-beat incrementing burst while master 0 waits
    do_reset();
    s_ack = 1'b1;
    set_m(1, 1, 1, 0, 32'h100, 32'h0, 3'b010, 2'b00, 4'hF);
    cycle();
    set_m(0, 1, 1, 1, 32'h200, 32'h55, 3'b000, 2'b00, 4'hF);
    beats = 0;
    for (int b = 0; b < 4; b++) begin
      set_m(1, 1, 1, 0, 32'(32'h100 + b * 4), 32'h0, (b == 3) ? 3'b111 : 3'b010, 2'b00, 4'hF);
      cycle();
      check("burst_gnt", 64'(sg), 64'h2);
      beats += int'(sa[1]);
    end
    check("burst_beats", 64'(beats), 64'd4);
    set_m(1, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00, 4'h0);
    cycle();
    check("burst_gap_scyc", 64'(sc), 64'd0);
    cycle();
    check("burst_next_gnt", 64'(sg), 64'h1);
    check("burst_next_ack", 64'(sa), 64'h1);
    set_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00, 4'h0);
    s_ack = 1'b0;
    cycle();

    // Watchdog: slave never answers
    do_reset();
    set_m(2, 1, 1, 0, 32'h40, 32'h0, 3'b000, 2'b00, 4'hF);
    cycle();
    for (int k = 1; k <= 9; k++) begin
      s_ack = (k == 9);
      cycle();
      check("wd_err", 64'(se), (k == 9) ? 64'h4 : 64'h0);
      if (k == 9) begin
        check("wd_stb_low",    64'(ss), 64'd0);
        check("wd_ack_ignored", 64'(sa), 64'd0);
      end
    end
    s_ack = 1'b0;
    cycle();
    check("wd_stb_again", 64'(ss), 64'd1);
    set_m(2, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00, 4'h0);
    cycle();

    // Reset in the middle of a master 3 burst
    do_reset();
    s_ack = 1'b1;
    set_m(3, 1, 1, 1, 32'h300, 32'h33, 3'b010, 2'b01, 4'hF);
    repeat (3) cycle();
    check("mid_gnt", 64'(sg), 64'h8);
    rst = 1'b1;
    cycle();
    check("rst_no_term", 64'(sa), 64'd0);
    rst = 1'b0;
    set_m(0, 1, 1, 0, 32'h0, 32'h0, 3'b000, 2'b00, 4'hF);
    cycle();
    check("post_rst_scyc", 64'(sc), 64'd0);
    check("post_rst_gnt",  64'(sg), 64'd0);
    cycle();
    check("post_rst_first", 64'(sg), 64'h1);

    // Randomized traffic
    do_reset();
    dead = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NM; i++) begin
        c = m_cyc[i];
        if (c) begin
          if ($urandom_range(5) == 0) c = 1'b0;
        end else if ($urandom_range(3) == 0) c = 1'b1;
        s = c ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
        set_m(i, c, s, 1'($urandom), $urandom, $urandom, 3'($urandom), 2'($urandom), 4'($urandom));
      end
      if (dead == 0 && $urandom_range(99) == 0) dead = 12;
      if (dead > 0) begin
        dead--;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      end else begin
        s_ack = 1'($urandom);
        s_err = ($urandom_range(15) == 0);
        s_rty = ($urandom_range(15) == 0);
      end
      s_dat_s2m = $urandom;
      rst = ($urandom_range(499) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
